// File: rtl/multdiv_ctrl_pkg.sv
// Shared types and constants for the multiply/divide sequencing controller.
package multdiv_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_t;

   localparam int          CNT_W           = 6;
   localparam int          RSTATUS_DEFAULT = 30;
   localparam logic [31:0] EXC_MULT        = 32'd4;
   localparam logic [31:0] EXC_DIV         = 32'd5;

endpackage

// File: rtl/md_watchdog.sv
// Saturating cycle counter that flags a multdiv operation overrunning TIMEOUT.
// Cleared synchronously on issue; expired stays high once the count reaches TIMEOUT.
module md_watchdog
   import multdiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 40
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != LIMIT)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LIMIT);

endmodule

// File: rtl/multdiv_ctrl.sv
// Issues one start pulse per mul/div in D/X, stalls the front end until the unit
// answers or the watchdog fires, then presents a single registered result.
module multdiv_ctrl
   import multdiv_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 40,
   parameter int RSTATUS = RSTATUS_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        dx_valid,
   input  logic        dx_is_mult,
   input  logic        dx_is_div,
   input  logic [4:0]  dx_rd,
   input  logic [31:0] dx_opA,
   input  logic [31:0] dx_opB,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_resultRDY,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] md_opA,
   output logic [31:0] md_opB,
   output logic        stall,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic [4:0]  res_rd,
   output logic        res_exc
);

   md_state_t state, state_n;

   logic       issue;
   logic       start_op;
   logic       res_load;
   logic       wd_clear;
   logic       wd_inc;
   logic       wd_expired;
   logic       stall_c;
   logic       is_div_q;
   logic [4:0] rd_q;

   assign issue = dx_valid & (dx_is_mult | dx_is_div);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      stall_c   = 1'b0;
      res_valid = 1'b0;
      start_op  = 1'b0;
      res_load  = 1'b0;
      wd_clear  = 1'b0;
      wd_inc    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (issue) begin
               stall_c  = 1'b1;
               start_op = 1'b1;
               wd_clear = 1'b1;
               state_n  = ST_START;
            end
         end
         // Counting from the pulse cycle puts expiry on the TIMEOUT-th BUSY cycle.
         ST_START: begin
            stall_c = 1'b1;
            wd_inc  = 1'b1;
            state_n = ST_BUSY;
         end
         ST_BUSY: begin
            stall_c = 1'b1;
            wd_inc  = 1'b1;
            if (md_resultRDY || wd_expired) begin
               res_load = 1'b1;
               state_n  = ST_DONE;
            end
         end
         ST_DONE: begin
            res_valid = 1'b1;
            state_n   = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // D/X may still hold an op while reset is high; keep stall low regardless.
   assign stall = stall_c & ~reset;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         md_opA    <= '0;
         md_opB    <= '0;
         rd_q      <= '0;
         is_div_q  <= 1'b0;
         ctrl_MULT <= 1'b0;
         ctrl_DIV  <= 1'b0;
         res_data  <= '0;
         res_rd    <= '0;
         res_exc   <= 1'b0;
      end else begin
         ctrl_MULT <= start_op & dx_is_mult;
         ctrl_DIV  <= start_op & ~dx_is_mult;
         if (start_op) begin
            md_opA   <= dx_opA;
            md_opB   <= dx_opB;
            rd_q     <= dx_rd;
            is_div_q <= ~dx_is_mult;
         end
         if (res_load) begin
            if (md_resultRDY && !md_exception) begin
               res_data <= md_result;
               res_rd   <= rd_q;
               res_exc  <= 1'b0;
            end else begin
               res_data <= is_div_q ? EXC_DIV : EXC_MULT;
               res_rd   <= 5'(RSTATUS);
               res_exc  <= 1'b1;
            end
         end
      end
   end

   md_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clock   (clock),
      .reset   (reset),
      .clear   (wd_clear),
      .inc     (wd_inc),
      .expired (wd_expired)
   );

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: a table of single operations plus
// hand-written stray-ready, back-to-back and reset-abort sequences.
module tb_multdiv_ctrl;

   logic        clock;
   logic        reset;
   logic        dx_valid, dx_is_mult, dx_is_div;
   logic [4:0]  dx_rd;
   logic [31:0] dx_opA, dx_opB;
   logic [31:0] md_result;
   logic        md_exception, md_resultRDY;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] md_opA, md_opB;
   logic        stall, res_valid;
   logic [31:0] res_data;
   logic [4:0]  res_rd;
   logic        res_exc;

   int tests = 0;
   int fails = 0;

   multdiv_ctrl #(.TIMEOUT(40), .RSTATUS(30)) dut (
      .clock        (clock),
      .reset        (reset),
      .dx_valid     (dx_valid),
      .dx_is_mult   (dx_is_mult),
      .dx_is_div    (dx_is_div),
      .dx_rd        (dx_rd),
      .dx_opA       (dx_opA),
      .dx_opB       (dx_opB),
      .md_result    (md_result),
      .md_exception (md_exception),
      .md_resultRDY (md_resultRDY),
      .ctrl_MULT    (ctrl_MULT),
      .ctrl_DIV     (ctrl_DIV),
      .md_opA       (md_opA),
      .md_opB       (md_opB),
      .stall        (stall),
      .res_valid    (res_valid),
      .res_data     (res_data),
      .res_rd       (res_rd),
      .res_exc      (res_exc)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // rdy_at: cycle (issue cycle = 0) carrying md_resultRDY, 0 = never.
   // stray: extra md_resultRDY in the start-pulse cycle.
   // chain: next vector issues in the cycle right after DONE.
   typedef struct {
      logic        is_mult;
      logic        is_div;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [4:0]  rd;
      int          rdy_at;
      logic [31:0] result;
      logic        exc_in;
      logic        stray;
      logic        chain;
      logic [31:0] exp_data;
      logic [4:0]  exp_rd;
      logic        exp_exc;
      int          exp_lat;
      int          exp_mpulse;
      int          exp_dpulse;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      dx_valid     = 1'b0;
      dx_is_mult   = 1'b0;
      dx_is_div    = 1'b0;
      md_resultRDY = 1'b0;
      md_exception = 1'b0;
   endtask

   task automatic run_op(input vec_t v);
      int lat;
      int mp;
      int dp;
      int gaps;
      logic [31:0] d;
      logic [4:0]  r;
      logic        e;
      logic        s;
      lat = -1; mp = 0; dp = 0; gaps = 0;
      d = '0; r = '0; e = 1'b0; s = 1'b1;
      @(negedge clock);
      dx_valid     = 1'b1;
      dx_is_mult   = v.is_mult;
      dx_is_div    = v.is_div;
      dx_opA       = v.op_a;
      dx_opB       = v.op_b;
      dx_rd        = v.rd;
      md_resultRDY = 1'b0;
      #1;
      chk("issue_stall", {31'b0, stall}, 32'd1);
      for (int c = 1; c <= 80; c++) begin
         @(negedge clock);
         md_resultRDY = (c == v.rdy_at) || (v.stray && c == 1);
         md_result    = (c == v.rdy_at) ? v.result : 32'hBAD0_0000;
         md_exception = (c == v.rdy_at) ? v.exc_in : 1'b1;
         #1;
         if (ctrl_MULT) mp++;
         if (ctrl_DIV)  dp++;
         if (res_valid) begin
            lat = c; d = res_data; r = res_rd; e = res_exc; s = stall;
            break;
         end
         if (stall !== 1'b1) gaps++;
      end
      md_resultRDY = 1'b0;
      chk("res_latency", lat, v.exp_lat);
      chk("res_data", d, v.exp_data);
      chk("res_rd", {27'b0, r}, {27'b0, v.exp_rd});
      chk("res_exc", {31'b0, e}, {31'b0, v.exp_exc});
      chk("stall_at_done", {31'b0, s}, 32'd0);
      chk("stall_gaps", gaps, 0);
      chk("mult_pulses", mp, v.exp_mpulse);
      chk("div_pulses", dp, v.exp_dpulse);
      chk("md_opA_held", md_opA, v.op_a);
      chk("md_opB_held", md_opB, v.op_b);
      if (!v.chain) begin
         @(negedge clock);
         idle_inputs();
         #1;
         chk("post_done_pulse", {30'b0, ctrl_MULT, ctrl_DIV}, 32'd0);
         chk("post_done_stall", {31'b0, stall}, 32'd0);
         chk("post_done_valid", {31'b0, res_valid}, 32'd0);
      end
   endtask

   vec_t vecs[9];
   int   any_valid;

   initial begin
      //          mul  div  opA           opB    rd  rdy  result        exc stray chain  data          rd  exc lat mp dp
      vecs[0] = '{1'b1,1'b0,32'd7,        32'd6, 5'd3, 18, 32'd42,       1'b0,1'b0,1'b0, 32'd42,       5'd3, 1'b0,19,1,0};
      vecs[1] = '{1'b0,1'b1,32'd5,        32'd0, 5'd7, 6,  32'd123,      1'b1,1'b0,1'b0, 32'd5,        5'd30,1'b1,7, 0,1};
      vecs[2] = '{1'b1,1'b0,32'd9,        32'd8, 5'd9, 0,  32'd0,        1'b0,1'b0,1'b0, 32'd4,        5'd30,1'b1,42,1,0};
      vecs[3] = '{1'b1,1'b0,32'hFFFF_FFFF,32'd2, 5'd31,2,  32'hDEADBEEF, 1'b0,1'b0,1'b0, 32'hDEADBEEF, 5'd31,1'b0,3, 1,0};
      vecs[4] = '{1'b0,1'b1,32'd100,      32'd3, 5'd12,41, 32'd99,       1'b0,1'b0,1'b0, 32'd99,       5'd12,1'b0,42,0,1};
      vecs[5] = '{1'b1,1'b1,32'd1,        32'd1, 5'd1, 4,  32'd77,       1'b1,1'b0,1'b0, 32'd4,        5'd30,1'b1,5, 1,0};
      vecs[6] = '{1'b0,1'b1,32'd34,       32'd2, 5'd2, 3,  32'd17,       1'b0,1'b1,1'b0, 32'd17,       5'd2, 1'b0,4, 0,1};
      vecs[7] = '{1'b1,1'b0,32'd50,       32'd20,5'd4, 5,  32'd1000,     1'b0,1'b0,1'b1, 32'd1000,     5'd4, 1'b0,6, 1,0};
      vecs[8] = '{1'b0,1'b1,32'd21,       32'd3, 5'd5, 3,  32'd7,        1'b0,1'b0,1'b0, 32'd7,        5'd5, 1'b0,4, 0,1};

      reset = 1'b1;
      idle_inputs();
      dx_rd = '0; dx_opA = '0; dx_opB = '0; md_result = '0;
      @(negedge clock);
      dx_valid = 1'b1; dx_is_mult = 1'b1;
      #1;
      chk("rst_outputs", {ctrl_MULT, ctrl_DIV, stall, res_valid, res_exc, res_rd}, 10'd0);
      chk("rst_res_data", res_data, 32'd0);
      chk("rst_md_opA", md_opA, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();

      // Stray ready while idle must not produce anything.
      @(negedge clock);
      md_resultRDY = 1'b1; md_result = 32'd66;
      any_valid = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         md_resultRDY = 1'b0;
         #1;
         if (res_valid || stall || ctrl_MULT || ctrl_DIV) any_valid++;
      end
      chk("idle_stray_rdy", any_valid, 0);

      for (int i = 0; i < 9; i++) run_op(vecs[i]);

      // Reset while BUSY: everything drops at once, late ready is ignored.
      @(negedge clock);
      dx_valid = 1'b1; dx_is_mult = 1'b1; dx_is_div = 1'b0;
      dx_opA = 32'd11; dx_opB = 32'd13; dx_rd = 5'd6;
      repeat (4) @(negedge clock);
      #1;
      chk("pre_reset_busy_stall", {31'b0, stall}, 32'd1);
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("reset_async_ctrl", {ctrl_MULT, ctrl_DIV, stall, res_valid, res_exc, res_rd}, 10'd0);
      chk("reset_async_opA", md_opA, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      #1;
      chk("after_reset_stall", {31'b0, stall}, 32'd0);
      @(negedge clock);
      md_resultRDY = 1'b1; md_result = 32'd55;
      any_valid = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         md_resultRDY = 1'b0;
         #1;
         if (res_valid || stall) any_valid++;
      end
      chk("late_rdy_ignored", any_valid, 0);
      run_op(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
